// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, default
// bus/memory/latency parameters and the width of the read-latency counter.
package lsu_pkg;

  localparam int unsigned DefDataLength = 32;
  localparam int unsigned DefMemLength  = 512;
  localparam int unsigned DefRdLatency  = 1;

  // Wide enough for the full rd_latency range 0..7.
  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request/response port and
// a word-addressed memory with a fixed read latency.
//
// Ports:
//   clk, rst            - sole clock, synchronous active-high reset
//   req_valid/req_ready - core request handshake; req_we selects write
//   req_addr/req_wdata  - word address and write data
//   resp_valid/ready    - response handshake; resp_rdata/resp_err payload
//   mem_addr/we/wdata   - memory command, held valid for one ACCESS cycle
//   mem_rdata           - memory read data, valid rd_latency cycles after ACCESS
//
// Every output is a flop. A write returns the word read back from the
// written address.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to reject addresses >= mem_length
// with resp_err=1 and no memory access. Without it the address is truncated
// and resp_err is tied low.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned data_length = DefDataLength,
  parameter int unsigned mem_length  = DefMemLength,
  parameter int unsigned rd_latency  = DefRdLatency
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [data_length-1:0]        req_addr,
  input  logic [data_length-1:0]        req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [data_length-1:0]        resp_rdata,
  output logic                          resp_err,
  output logic [$clog2(mem_length)-1:0] mem_addr,
  output logic                          mem_we,
  output logic [data_length-1:0]        mem_wdata,
  input  logic [data_length-1:0]        mem_rdata
);

  localparam int unsigned AddrW = $clog2(mem_length);
  localparam logic [CntW-1:0] LatInit = CntW'(rd_latency);

  lsu_state_e             state_d, state_q;
  logic [CntW-1:0]        cnt_d, cnt_q;
  logic                   we_d, we_q;
  logic [AddrW-1:0]       addr_d, addr_q;
  logic [data_length-1:0] wdata_d, wdata_q;
  logic                   req_ready_d, req_ready_q;
  logic                   mem_we_d, mem_we_q;
  logic [AddrW-1:0]       mem_addr_d, mem_addr_q;
  logic [data_length-1:0] mem_wdata_d, mem_wdata_q;
  logic                   resp_valid_d, resp_valid_q;
  logic [data_length-1:0] resp_rdata_d, resp_rdata_q;
  logic                   accept;
  logic                   req_oob;

  // req_ready_q is only high in IDLE, so acceptance implies IDLE.
  assign accept = req_valid & req_ready_q;

`ifdef LSU_BOUNDS_CHECK_EN
  logic resp_err_d, resp_err_q;

  assign req_oob = (req_addr >= data_length'(mem_length));

  always_comb begin
    resp_err_d = resp_err_q;
    if (state_q == StIdle && state_d == StResp) begin
      resp_err_d = 1'b1;
    end else if (state_d != StResp) begin
      resp_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
`else
  logic unused_addr_hi;

  // Upper address bits are dropped: the address wraps onto the memory.
  assign unused_addr_hi = ^req_addr[data_length-1:AddrW];
  assign req_oob        = 1'b0;
  assign resp_err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = req_oob ? StResp : StAccess;
        end
      end
      StAccess: state_d = (rd_latency == 0) ? StResp : StWait;
      StWait: begin
        // Counter reaches zero on this edge: data is valid now.
        if (cnt_q <= CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next-state logic, keyed on the upcoming state so the
  // registered outputs line up with state_q.
  always_comb begin
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;

    if (accept) begin
      we_d    = req_we;
      addr_d  = req_addr[AddrW-1:0];
      wdata_d = req_wdata;
    end

    if (state_d == StAccess) begin
      mem_we_d    = we_d;
      mem_addr_d  = addr_d;
      mem_wdata_d = wdata_d;
    end

    if (state_q == StAccess) begin
      cnt_d = LatInit;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q - CntW'(1);
    end

    if ((state_q == StAccess || state_q == StWait) && state_d == StResp) begin
      resp_rdata_d = mem_rdata;
    end else if (state_q == StIdle && state_d == StResp) begin
      resp_rdata_d = '0;
    end

    req_ready_d  = (state_d == StIdle);
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Three lanes with rd_latency 0, 1 and 3
// share clock and reset; each lane has its own memory model (write-first
// read, rd_latency-deep read pipeline, word a preloaded with 0xA0000000|a).
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic [8:0]  mem_addr   [3];
  logic        mem_we     [3];
  logic [31:0] mem_wdata  [3];
  logic [31:0] mem_rdata  [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int unsigned L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [31:0] mem  [512];
    logic [31:0] pipe [4];
    logic [31:0] rd_now;
    int unsigned we_cnt;

    load_store_unit #(
      .data_length(32),
      .mem_length (512),
      .rd_latency (L)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .mem_addr  (mem_addr[g]),
      .mem_we    (mem_we[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    assign rd_now = mem_we[g] ? mem_wdata[g] : mem[mem_addr[g]];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int a = 0; a < 512; a++) mem[a] <= 32'hA000_0000 | 32'(a);
        we_cnt <= 0;
      end else if (mem_we[g]) begin
        mem[mem_addr[g]] <= mem_wdata[g];
        we_cnt <= we_cnt + 1;
      end
      pipe[0] <= rd_now;
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end

    if (L == 0) begin : g_comb
      assign mem_rdata[g] = rd_now;
    end else begin : g_pipe
      assign mem_rdata[g] = pipe[L-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ACCESS (or RESP) cycle.
  task automatic accept_req(input int k, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    int n;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  // Counts cycles from the acceptance cycle until resp_valid is seen.
  task automatic wait_resp(input int k, output int lat);
    lat = 1;
    while (!resp_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_resp(input int k, input string tag, input logic [31:0] exp_data,
                           input logic exp_err);
    check({tag, "_valid"}, 32'(resp_valid[k]), 32'd1);
    check({tag, "_rdata"}, resp_rdata[k], exp_data);
    check({tag, "_err"}, 32'(resp_err[k]), 32'(exp_err));
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int unsigned w0;
    int acc;
    int got;
    int cyc;
    int seen;
    logic acc_now;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_we[k]     = 1'b0;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      resp_ready[k] = 1'b0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready[1]), 32'd0);
    check("rst_resp_valid", 32'(resp_valid[1]), 32'd0);
    check("rst_resp_err", 32'(resp_err[1]), 32'd0);
    check("rst_resp_rdata", resp_rdata[1], 32'd0);
    check("rst_mem_we", 32'(mem_we[1]), 32'd0);
    check("rst_mem_addr", 32'(mem_addr[1]), 32'd0);
    check("rst_mem_wdata", mem_wdata[1], 32'd0);
    rst = 1'b0;
    check("rst_release_ready_low", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    check("rst_release_ready_l0", 32'(req_ready[0]), 32'd1);
    check("rst_release_ready_l1", 32'(req_ready[1]), 32'd1);
    check("rst_release_ready_l2", 32'(req_ready[2]), 32'd1);

    // Write then read back, rd_latency=1.
    w0 = g_lane[1].we_cnt;
    accept_req(1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    check("wr_access_we", 32'(mem_we[1]), 32'd1);
    check("wr_access_addr", 32'(mem_addr[1]), 32'd5);
    wait_resp(1, lat);
    check("wr_latency", 32'(lat), 32'd3);
    take_resp(1, "wr", 32'hDEAD_BEEF, 1'b0);
    check("wr_we_cycles", g_lane[1].we_cnt - w0, 32'd1);
    w0 = g_lane[1].we_cnt;
    accept_req(1, 1'b0, 32'd5, 32'h0);
    check("rd_access_we", 32'(mem_we[1]), 32'd0);
    wait_resp(1, lat);
    check("rd_latency", 32'(lat), 32'd3);
    take_resp(1, "rd", 32'hDEAD_BEEF, 1'b0);
    check("rd_we_cycles", g_lane[1].we_cnt - w0, 32'd0);

    // Latency sweep.
    accept_req(0, 1'b0, 32'd2, 32'h0);
    wait_resp(0, lat);
    check("lat0_latency", 32'(lat), 32'd2);
    take_resp(0, "lat0", 32'hA000_0002, 1'b0);
    accept_req(2, 1'b0, 32'd2, 32'h0);
    wait_resp(2, lat);
    check("lat3_latency", 32'(lat), 32'd5);
    take_resp(2, "lat3", 32'hA000_0002, 1'b0);

    // Backpressure with a competing request held on the port.
    accept_req(1, 1'b0, 32'd7, 32'h0);
    wait_resp(1, lat);
    check("bp_latency", 32'(lat), 32'd3);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'd9;
    for (int i = 0; i < 4; i++) begin
      check("bp_resp_valid", 32'(resp_valid[1]), 32'd1);
      check("bp_resp_rdata", resp_rdata[1], 32'hA000_0007);
      check("bp_req_ready", 32'(req_ready[1]), 32'd0);
      check("bp_mem_addr", 32'(mem_addr[1]), 32'd7);
      @(negedge clk);
    end
    resp_ready[1] = 1'b1;
    @(negedge clk);
    resp_ready[1] = 1'b0;
    check("bp_idle_ready", 32'(req_ready[1]), 32'd1);
    check("bp_idle_valid", 32'(resp_valid[1]), 32'd0);
    check("bp_not_accepted", 32'(mem_addr[1]), 32'd7);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("bp_second_addr", 32'(mem_addr[1]), 32'd9);
    wait_resp(1, lat);
    check("bp_second_latency", 32'(lat), 32'd3);
    take_resp(1, "bp_second", 32'hA000_0009, 1'b0);

    // Back-to-back reads with req_valid held high.
    req_valid[1]  = 1'b1;
    req_we[1]     = 1'b0;
    req_addr[1]   = 32'd1;
    resp_ready[1] = 1'b1;
    acc = 0;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 100) begin
      acc_now = 1'b0;
      if (resp_valid[1]) begin
        check("b2b_rdata", resp_rdata[1], 32'hA000_0000 + 32'(got + 1));
        got++;
      end
      if (req_valid[1] && req_ready[1]) begin
        check("b2b_accept_idle", 32'(resp_valid[1]), 32'd0);
        acc++;
        acc_now = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (acc < 3) req_addr[1] = 32'(acc + 1);
        else req_valid[1] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    resp_ready[1] = 1'b0;
    check("b2b_responses", 32'(got), 32'd3);
    check("b2b_accepts", 32'(acc), 32'd3);

    // Out-of-range write to word 600.
    @(negedge clk);
    w0 = g_lane[1].we_cnt;
    accept_req(1, 1'b1, 32'd600, 32'h1234_5678);
`ifdef LSU_BOUNDS_CHECK_EN
    check("oob_mem_we", 32'(mem_we[1]), 32'd0);
    wait_resp(1, lat);
    check("oob_latency", 32'(lat), 32'd1);
    take_resp(1, "oob", 32'h0, 1'b1);
    check("oob_we_cycles", g_lane[1].we_cnt - w0, 32'd0);
`else
    check("wrap_mem_addr", 32'(mem_addr[1]), 32'd88);
    check("wrap_mem_we", 32'(mem_we[1]), 32'd1);
    wait_resp(1, lat);
    check("wrap_latency", 32'(lat), 32'd3);
    take_resp(1, "wrap", 32'h1234_5678, 1'b0);
    check("wrap_we_cycles", g_lane[1].we_cnt - w0, 32'd1);
    check("wrap_mem_word", g_lane[1].mem[88], 32'h1234_5678);
`endif

    // Reset pulse during WAIT on the rd_latency=3 lane.
    accept_req(2, 1'b0, 32'd4, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_req_ready", 32'(req_ready[2]), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid[2]), 32'd0);
    check("mid_rst_resp_rdata", resp_rdata[2], 32'd0);
    check("mid_rst_resp_err", 32'(resp_err[2]), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we[2]), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr[2]), 32'd0);
    check("mid_rst_mem_wdata", mem_wdata[2], 32'd0);
    @(negedge clk);
    check("mid_rst_ready_after", 32'(req_ready[2]), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid[2]) seen++;
      @(negedge clk);
    end
    check("mid_rst_no_resp", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter data_length, default 32: width of request, write and read data buses.
REQ-002 The module SHALL have parameter mem_length, default 512: number of memory words addressable.
REQ-003 The module SHALL have parameter rd_latency, default 1, range 0..7: cycles between address issue and valid mem_rdata.
REQ-004 The module SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset).
REQ-005 The module SHALL have port req_valid (in, 1): core request present.
REQ-006 The module SHALL have port req_ready (out, 1): request accepted when high with req_valid.
REQ-007 The module SHALL have ports req_we (in, 1, 0=read 1=write), req_addr (in, data_length, word address) and req_wdata (in, data_length).
REQ-008 The module SHALL have ports resp_valid (out, 1), resp_ready (in, 1), resp_rdata (out, data_length) and resp_err (out, 1).
REQ-009 The module SHALL have ports mem_addr (out, $clog2(mem_length)), mem_we (out, 1), mem_wdata (out, data_length) and mem_rdata (in, data_length) toward the memory.

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS, WAIT, RESP, with every output registered.
REQ-011 In IDLE the unit SHALL drive req_ready=1 and, on req_valid&req_ready, latch we/addr/wdata and go to ACCESS next cycle.
REQ-012 In ACCESS the unit SHALL drive mem_addr=latched addr[low bits], mem_wdata=latched wdata and mem_we=latched we for exactly one cycle.
REQ-013 After ACCESS the unit SHALL go to WAIT, load a down-counter with rd_latency, and go directly to RESP when rd_latency=0.
REQ-014 In WAIT the counter SHALL decrement once per cycle, and mem_rdata SHALL be captured into resp_rdata on the cycle the counter reaches 0, followed by entry to RESP.
REQ-015 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1, after which the unit goes to IDLE the next cycle.
REQ-016 A write SHALL return the read-back word at the written address in resp_rdata.
REQ-017 req_ready SHALL be 0 in ACCESS, WAIT and RESP, so at most one request is outstanding.
REQ-018 mem_we SHALL be 0 in every state other than ACCESS.
REQ-019 A req_valid arriving in the same cycle that RESP completes SHALL NOT be accepted until the unit is in IDLE.
REQ-020 Best-case latency from acceptance to resp_valid SHALL be 2+rd_latency cycles.

Reset
REQ-021 While rst=1 at a clk edge, the unit SHALL force state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0 and counter=0.
REQ-022 Reset asserted mid-operation SHALL abort the transaction with no response issued and mem_we=0 from the next edge.
REQ-023 req_ready SHALL rise the first cycle after rst deasserts.

Configuration
REQ-024 With LSU_BOUNDS_CHECK_EN defined, a request whose req_addr >= mem_length SHALL skip ACCESS/WAIT (mem_we stays 0) and go to RESP with resp_err=1 and resp_rdata=0.
REQ-025 Without LSU_BOUNDS_CHECK_EN, req_addr SHALL be truncated to $clog2(mem_length) bits and resp_err SHALL be tied to 0.

Structure
REQ-026 Package lsu_pkg SHALL hold the FSM state enum and the default data_length/mem_length/rd_latency constants.
REQ-027 The unit SHALL have no sub-module, with the FSM and latency counter in one module.

Verification
REQ-028 Write then read, rd_latency=1: write addr 5 data 0xDEADBEEF, then read addr 5 -> both responses return resp_rdata=0xDEADBEEF, resp_err=0, with mem_we high exactly 1 cycle for the write.
REQ-029 Latency sweep: rd_latency=0 and 3, read addr 2 -> resp_valid 2 and 5 cycles after acceptance respectively.
REQ-030 Backpressure: resp_ready held 0 for 4 cycles -> resp_valid and resp_rdata stable, req_ready=0 and no second request accepted.
REQ-031 Reset mid-WAIT: rst pulsed one cycle -> no resp_valid, all outputs at reset values, and req_ready=1 one cycle after release.
REQ-032 Bounds check: with LSU_BOUNDS_CHECK_EN, a write to addr 600 -> resp_err=1, resp_rdata=0 and mem_we never asserted; without the macro, the access goes to addr 88.
REQ-033 Back-to-back: req_valid held high for 3 reads (addr 1,2,3) -> three in-order responses, each accepted only from IDLE.
